inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 159 +++++++++++++++
 tb/tb_inst_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs U/I/S/B/J field bundles into 32-bit words
// through a two-stage valid/ready pipeline with saturating good/error word counters.
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and its payload until that edge; ready may depend
  // combinationally on downstream ready (in_ready follows out_ready).

  logic        s1_valid;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;

  logic        s1_advance;
  logic        in_fire;
  logic        out_fire;

  logic [31:0] enc_raw;
  logic        enc_err;
  logic [31:0] enc_instr;

  logic        imm_fits_11;
  logic        imm_fits_12;
  logic        imm_fits_20;

  assign s1_advance = s1_valid && (!s2_valid || out_ready);
  assign in_ready   = !rst && (!s1_valid || s1_advance);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = s2_valid && out_ready;

  assign out_valid  = s2_valid;
  assign out_instr  = s2_instr;
  assign out_err    = s2_err;

  // Immediate range checks: upper bits must be a pure sign extension.
  assign imm_fits_11 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign imm_fits_12 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
  assign imm_fits_20 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

  always_comb begin
    enc_raw = NOP;
    enc_err = 1'b1;
    case (s1_opcode)
      OP_LUI: begin
        enc_raw = {s1_imm[31:12], s1_rd, s1_opcode};
        enc_err = |s1_imm[11:0];
      end
      OP_IMM, OP_LOAD: begin
        enc_raw = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_err = !imm_fits_11;
      end
      OP_STORE: begin
        enc_raw = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_err = !imm_fits_11;
      end
      OP_BRANCH: begin
        enc_raw = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                   s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_err = s1_imm[0] || !imm_fits_12;
      end
      OP_JAL: begin
        enc_raw = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        enc_err = s1_imm[0] || !imm_fits_20;
      end
      default: begin
        enc_raw = NOP;
        enc_err = 1'b1;
      end
    endcase
    enc_instr = enc_err ? NOP : enc_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_imm    <= '0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_opcode <= opcode;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_funct3 <= funct3;
      s1_imm    <= imm;
    end else if (s1_advance) begin
      s1_valid  <= 1'b0;
    end
  end

  // S2 only reloads when empty or being consumed, so the word is stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= 1'b1;
      s2_instr <= enc_instr;
      s2_err   <= enc_err;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (out_fire) begin
      if (s2_err) begin
        if (cnt_err != '1) cnt_err <= cnt_err + CNT_ONE;
      end else begin
        if (cnt_ok != '1) cnt_ok <= cnt_ok + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, error cases, backpressure,
// mid-operation reset, counter saturation and clear precedence.
module tb_inst_encoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  int n_checks;
  int n_fail;
  int exp_ok;
  int exp_err;
  int bad_ready;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .clr_cnt   (clr_cnt),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                            input logic [4:0] rs2_v, input logic [2:0] f3, input logic [31:0] im);
    opcode = op;
    rd     = rd_v;
    rs1    = rs1_v;
    rs2    = rs2_v;
    funct3 = f3;
    imm    = im;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, ".cnt_ok"},  32'(cnt_ok),  32'(exp_ok));
    chk({tag, ".cnt_err"}, 32'(cnt_err), 32'(exp_err));
  endtask

  // One bundle through an idle pipeline with out_ready=1: checks latency 2 and counters.
  task automatic xfer(input string tag, input logic [6:0] op, input logic [4:0] rd_v,
                      input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                      input logic [31:0] im, input logic [31:0] exp_i, input logic exp_e);
    set_fields(op, rd_v, rs1_v, rs2_v, f3, im);
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".valid_n1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".valid_n2"}, 32'(out_valid), 32'd1);
    chk({tag, ".instr"}, out_instr, exp_i);
    chk({tag, ".err"}, 32'(out_err), 32'(exp_e));
    tick();
    if (exp_e) begin
      if (exp_err < 65535) exp_err++;
    end else begin
      if (exp_ok < 65535) exp_ok++;
    end
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    chk_counters(tag);
  endtask

  // scoreboard-free directed sequence; expected values are hand-computed encodings
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_ok    = 0;
    exp_err   = 0;
    bad_ready = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);

    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_instr", out_instr, 32'h0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk_counters("rst");
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    xfer("addi",    7'b0010011, 5'd1, 5'd0,  5'd0,  3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    xfer("lui",     7'b0110111, 5'd5, 5'd0,  5'd0,  3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    xfer("lui_junk",7'b0110111, 5'd5, 5'd31, 5'd31, 3'd7, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    xfer("sw",      7'b0100011, 5'd0, 5'd1,  5'd2,  3'd2, 32'h0000_0004, 32'h0020_A223, 1'b0);
    xfer("beq",     7'b1100011, 5'd0, 5'd1,  5'd2,  3'd0, 32'h0000_0008, 32'h0020_8463, 1'b0);
    xfer("bne_neg", 7'b1100011, 5'd0, 5'd5,  5'd6,  3'd1, 32'hFFFF_FFF8, 32'hFE62_9CE3, 1'b0);
    xfer("jal",     7'b1101111, 5'd1, 5'd0,  5'd0,  3'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    xfer("lw",      7'b0000011, 5'd3, 5'd2,  5'd0,  3'd2, 32'hFFFF_FFFC, 32'hFFC1_2183, 1'b0);
    xfer("br_odd",  7'b1100011, 5'd0, 5'd1,  5'd2,  3'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    xfer("imm_rng", 7'b0010011, 5'd1, 5'd0,  5'd0,  3'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    xfer("lui_low", 7'b0110111, 5'd5, 5'd0,  5'd0,  3'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    xfer("jal_odd", 7'b1101111, 5'd1, 5'd0,  5'd0,  3'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    xfer("sw_rng",  7'b0100011, 5'd0, 5'd1,  5'd2,  3'd2, 32'h0000_1000, 32'h0000_0013, 1'b1);
    xfer("bad_op",  7'b0110011, 5'd1, 5'd2,  5'd3,  3'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);

    // Backpressure: two bundles fill the pipe, the third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 32'd5);
    chk("bp.a_ready", 32'(in_ready), 32'd1);
    tick();
    set_fields(7'b0010011, 5'd3, 5'd1, 5'd0, 3'd0, 32'd6);
    chk("bp.b_ready", 32'(in_ready), 32'd1);
    tick();
    set_fields(7'b0010011, 5'd4, 5'd1, 5'd0, 3'd0, 32'd7);
    chk("bp.c_blocked", 32'(in_ready), 32'd0);
    chk("bp.a_valid", 32'(out_valid), 32'd1);
    chk("bp.a_instr", out_instr, 32'h0050_8113);
    tick();
    chk("bp.c_still_blocked", 32'(in_ready), 32'd0);
    chk("bp.a_stable", out_instr, 32'h0050_8113);
    chk_counters("bp.hold");
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    exp_ok++;
    chk("bp.b_valid", 32'(out_valid), 32'd1);
    chk("bp.b_instr", out_instr, 32'h0060_8193);
    tick();
    exp_ok++;
    chk("bp.c_valid", 32'(out_valid), 32'd1);
    chk("bp.c_instr", out_instr, 32'h0070_8213);
    tick();
    exp_ok++;
    chk("bp.empty", 32'(out_valid), 32'd0);
    chk_counters("bp.done");

    // Reset with both stages full drops everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("mid_rst.full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
    tick();
    rst     = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out_instr", out_instr, 32'h0);
    chk_counters("mid_rst");
    out_ready = 1'b1;
    tick();
    tick();
    chk("mid_rst.no_ghost", 32'(out_valid), 32'd0);
    chk_counters("mid_rst.after");

    // Streaming at full rate past the cnt_ok saturation point.
    in_valid = 1'b1;
    set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    for (int i = 0; i < 65540; i++) begin
      if (!in_ready) bad_ready++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    exp_ok = 65535;
    chk("sat.throughput_stalls", 32'(bad_ready), 32'd0);
    chk_counters("sat");
    xfer("sat.extra", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);

    // clr_cnt coincides with an output handshake: clear wins, word still leaves.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr.word_waiting", 32'(out_valid), 32'd1);
    clr_cnt   = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_cnt = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    chk("clr.consumed", 32'(out_valid), 32'd0);
    chk_counters("clr");
    xfer("clr.after", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
